// File: rtl/km_pkg.sv
// km_pkg: shared state encoding, cluster ids and default widths for the centroid update stage.
package km_pkg;
  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;
  localparam logic [1:0] C1 = 2'd0;
  localparam logic [1:0] C2 = 2'd1;
  localparam logic [1:0] C3 = 2'd2;
  localparam logic [1:0] C_BAD = 2'd3;
  localparam int NUM_CLUSTERS = 3;
  localparam int COORD_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/km_serial_div.sv
// km_serial_div: unsigned restoring divider, one quotient bit per cycle, W cycles after start.
module km_serial_div #(
  parameter int W = 32,
  parameter int QW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic [QW-1:0] quotient,
  output logic          done
);
  localparam int NW = $clog2(W + 1);
  logic [W-1:0] rem, quo, dvs, rem_next, quo_next;
  logic [NW-1:0] n;
  logic [W:0] sh;
  logic ge;
  always_comb begin
    sh = {rem, quo[W-1]};
    ge = sh >= {1'b0, dvs};
    rem_next = ge ? sh[W-1:0] - dvs : sh[W-1:0];
    quo_next = {quo[W-2:0], ge};
  end
  // quotient is the result of the iteration in flight, valid while done is high
  assign quotient = quo_next[QW-1:0];
  assign done = n == NW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      n <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      n <= NW'(W);
    end else if (n != '0) begin
      rem <= rem_next;
      quo <= quo_next;
      n <= n - 1'b1;
    end
  end
endmodule

// File: rtl/kmeans_centroid_update.sv
// kmeans_centroid_update: per-cluster sum/count accumulation and serial-divide centroid refresh; KM_CONVERGE_EN adds the converged flag.
module kmeans_centroid_update
  import km_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = COORD_W + CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  input  logic [COORD_W-1:0]     pt_x,
  input  logic [COORD_W-1:0]     pt_y,
  input  logic [1:0]             cluster_id,
  input  logic                   pass_end,
  input  logic                   init_load,
  input  logic [3*COORD_W-1:0]   init_cx,
  input  logic [3*COORD_W-1:0]   init_cy,
  output logic [3*COORD_W-1:0]   cent_x,
  output logic [3*COORD_W-1:0]   cent_y,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
`ifdef KM_CONVERGE_EN
  output logic                   converged,
`endif
  output logic                   bad_id
);
  localparam int CW = $clog2(SUM_W + 1);
  localparam logic [CW-1:0] LAST = CW'(SUM_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state;
  logic [2:0] slot;
  logic [CW-1:0] cyc;
  logic [SUM_W-1:0] sum_x [NUM_CLUSTERS];
  logic [SUM_W-1:0] sum_y [NUM_CLUSTERS];
  logic [CNT_W-1:0] cnt [NUM_CLUSTERS];
  logic [1:0] k;
  logic take, dv_start, dv_done, wr;
  logic [SUM_W-1:0] dv_a, dv_b;
  logic [COORD_W-1:0] q;
  // slot order C1x, C1y, C2x, C2y, C3x, C3y: cluster in slot[2:1], axis in slot[0]
  assign k = slot[2:1];
  assign take = pt_valid && pt_ready;
  assign dv_start = state == DIVIDE && cyc == '0;
  assign dv_a = slot[0] ? sum_y[k] : sum_x[k];
  assign dv_b = SUM_W'(cnt[k]);
  assign wr = state == DIVIDE && dv_done && cnt[k] != '0;
  km_serial_div #(.W(SUM_W), .QW(COORD_W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(dv_start),
    .dividend(dv_a),
    .divisor(dv_b),
    .quotient(q),
    .done(dv_done)
  );
`ifdef KM_CONVERGE_EN
  logic same;
  logic [COORD_W-1:0] old;
  assign old = slot[0] ? cent_y[k*COORD_W +: COORD_W] : cent_x[k*COORD_W +: COORD_W];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      slot <= '0;
      cyc <= '0;
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        sum_x[i] <= '0;
        sum_y[i] <= '0;
        cnt[i] <= '0;
      end
      cent_x <= '0;
      cent_y <= '0;
      pt_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      bad_id <= 1'b0;
`ifdef KM_CONVERGE_EN
      same <= 1'b0;
      converged <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ACCUM: begin
          if (take) begin
            if (cluster_id == C_BAD) bad_id <= 1'b1;
            else if (cnt[cluster_id] == CNT_MAX) ovf <= 1'b1;
            else begin
              sum_x[cluster_id] <= sum_x[cluster_id] + SUM_W'(pt_x);
              sum_y[cluster_id] <= sum_y[cluster_id] + SUM_W'(pt_y);
              cnt[cluster_id] <= cnt[cluster_id] + 1'b1;
            end
          end
          if (init_load) begin
            cent_x <= init_cx;
            cent_y <= init_cy;
`ifdef KM_CONVERGE_EN
            converged <= 1'b0;
`endif
          end else if (pass_end) begin
            state <= DIVIDE;
            pt_ready <= 1'b0;
            busy <= 1'b1;
            slot <= '0;
            cyc <= '0;
`ifdef KM_CONVERGE_EN
            same <= 1'b1;
`endif
          end
        end
        DIVIDE: begin
          if (wr) begin
            if (slot[0]) cent_y[k*COORD_W +: COORD_W] <= q;
            else cent_x[k*COORD_W +: COORD_W] <= q;
`ifdef KM_CONVERGE_EN
            if (q != old) same <= 1'b0;
`endif
          end
          cyc <= cyc == LAST ? '0 : cyc + 1'b1;
          if (cyc == LAST) begin
            slot <= slot + 1'b1;
            if (slot == 3'd5) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: begin
          for (int i = 0; i < NUM_CLUSTERS; i++) begin
            sum_x[i] <= '0;
            sum_y[i] <= '0;
            cnt[i] <= '0;
          end
          state <= ACCUM;
          pt_ready <= 1'b1;
`ifdef KM_CONVERGE_EN
          converged <= same;
`endif
        end
      endcase
    end
  end
endmodule
